instr_fetch_unit: RTL

//   Instruction fetch front end that feeds the control/datapath decoder. Owns the PC.

---
 rtl/instr_fetch_unit_pkg.sv | 13 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 47 ++++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM states and fetch constants.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO used for both the instruction buffer and the in-flight PC tag queue.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [W-1:0]                   push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic [W-1:0]                   head,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_pop  = pop & (count != '0);
    // a full FIFO still takes a write when the head leaves in the same cycle
    assign do_push = push & ((count < CW'(DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order imem requests, buffers responses.
// Optional misaligned-redirect trap under FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            fetch_fault
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e      state, state_nxt;
    logic [XLEN-1:0]   pc, target, tag_pc;
    logic [CW-1:0]     outstanding, outstanding_nxt, drop, fifo_count, unused_tag_count;
    logic [2*XLEN-1:0] fifo_head;
    logic              accept, redirect, misalign, rsp_ok, dropping, fifo_push, fifo_pop;

    assign redirect = PCSrc & (state == RUN);

`ifdef FETCH_ALIGN_CHECK_EN
    assign target   = PCTarget;
    assign misalign = redirect & (PCTarget[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign unused_lsb = ^PCTarget[1:0];
    assign target     = {PCTarget[XLEN-1:2], 2'b00};
    assign misalign   = 1'b0;
`endif

    // outstanding counts every request in flight, dropped or not, so the issue limit bounds drop too
    assign imem_req_valid  = (state == RUN) &&
                             (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr   = pc;
    assign accept          = imem_req_valid & imem_req_ready;
    assign rsp_ok          = imem_rsp_valid & (outstanding != '0);
    assign dropping        = rsp_ok & (drop != '0);
    assign fifo_push       = rsp_ok & ~dropping & ~redirect;
    assign fifo_pop        = instr_valid & instr_ready;
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp_ok);

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (misalign) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            if (redirect)      pc <= target;
            else if (accept)   pc <= pc + XLEN'(INSTR_BYTES);
            if (redirect)      drop <= outstanding_nxt;
            else if (dropping) drop <= drop - CW'(1);
        end
    end

    // PC tags of live (non-dropped) requests, oldest first
    fetch_fifo #(.W(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .push      (accept & ~redirect),
        .push_data (pc),
        .pop       (rsp_ok & ~dropping),
        .flush     (redirect),
        .head      (tag_pc),
        .count     (unused_tag_count)
    );

    fetch_fifo #(.W(2*XLEN), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({tag_pc, imem_rsp_data}),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = fifo_head[XLEN-1:0];
    assign instr_pc    = fifo_head[2*XLEN-1:XLEN];

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    always_ff @(posedge clk) begin
        if (reset)         fault_q <= 1'b0;
        else if (misalign) fault_q <= 1'b1;
    end
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
